// File: rtl/des_core_arbiter_if.sv
// Requester and DES-core signal bundle for des_core_arbiter.
// slave = arbiter side, master = requesters plus core side.
interface des_core_arbiter_if;
  logic         req0;
  logic         req1;
  logic [1:64]  msg0;
  logic [1:64]  msg1;
  logic [1:768] keys0;
  logic [1:768] keys1;
  logic         ack0;
  logic         ack1;
  logic         rvalid0;
  logic         rvalid1;
  logic         rready0;
  logic         rready1;
  logic [1:64]  rdata;
  logic         rerr;
  logic         busy;
  logic         core_start;
  logic [1:64]  core_message;
  logic [1:768] core_round_keys;
  logic         core_done;
  logic [1:64]  core_result;

  modport slave (
    input  req0, req1, msg0, msg1, keys0, keys1, rready0, rready1,
    input  core_done, core_result,
    output ack0, ack1, rvalid0, rvalid1, rdata, rerr, busy,
    output core_start, core_message, core_round_keys
  );

  modport master (
    output req0, req1, msg0, msg1, keys0, keys1, rready0, rready1,
    output core_done, core_result,
    input  ack0, ack1, rvalid0, rvalid1, rdata, rerr, busy,
    input  core_start, core_message, core_round_keys
  );
endinterface

// File: rtl/des_core_arbiter.sv
// Round-robin sharing of one DES core between two requesters: operand latching,
// start/done sequencing, result hold until accepted, and a completion timeout.
module des_core_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  des_core_arbiter_if.slave bus
);
  localparam int unsigned   MW    = 64;
  localparam int unsigned   KW    = 768;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TSAT  = {TW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_last;
  logic [TW-1:0] r_timer;
  logic [1:MW]   r_msg;
  logic [1:KW]   r_keys;
  logic [1:MW]   r_rdata;
  logic          r_rerr;
  logic          r_start;
  logic          r_busy;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Grant favours the requester that did not win last time when both ask.
  always_comb begin
    w_next    = r_state;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt0 = bus.req0 & (~bus.req1 | r_last);
        w_gnt1 = bus.req1 & (~bus.req0 | ~r_last);
        if (w_gnt0 | w_gnt1) w_next = S_START;
      end
      S_START: w_next = S_BUSY;
      S_BUSY: begin
        if (bus.core_done) begin
          w_next = S_RESP;
        end else if (r_timer == TLAST) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        if (r_owner ? bus.rready1 : bus.rready0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_timer   <= '0;
      r_msg     <= '0;
      r_keys    <= '0;
      r_rdata   <= '0;
      r_rerr    <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_start   <= (w_next == S_START);
      r_busy    <= (w_next != S_IDLE);
      r_rvalid0 <= (w_next == S_RESP) && !r_owner;
      r_rvalid1 <= (w_next == S_RESP) && r_owner;
      if (w_gnt0 || w_gnt1) begin
        r_owner <= w_gnt1;
        r_msg   <= w_gnt1 ? bus.msg1  : bus.msg0;
        r_keys  <= w_gnt1 ? bus.keys1 : bus.keys0;
      end
      // Timer only runs in BUSY and saturates rather than wrapping.
      if (r_state == S_START) begin
        r_timer <= '0;
      end else if (r_state == S_BUSY && r_timer != TSAT) begin
        r_timer <= r_timer + TW'(1);
      end
      if (r_state == S_BUSY) begin
        if (bus.core_done) begin
          r_rdata <= bus.core_result;
          r_rerr  <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_rerr  <= 1'b1;
        end
      end
      if (r_state == S_RESP && w_next == S_IDLE) r_last <= r_owner;
    end
  end

  assign bus.ack0            = w_gnt0 & ~rst;
  assign bus.ack1            = w_gnt1 & ~rst;
  assign bus.rvalid0         = r_rvalid0;
  assign bus.rvalid1         = r_rvalid1;
  assign bus.rdata           = r_rdata;
  assign bus.rerr            = r_rerr;
  assign bus.busy            = r_busy;
  assign bus.core_start      = r_start;
  assign bus.core_message    = r_msg;
  assign bus.core_round_keys = r_keys;
endmodule

// File: tb/tb_des_core_arbiter.sv
// Bench for des_core_arbiter: stub DES core, vector table of transactions with a
// result scoreboard, plus hand sequences for stray done pulses and mid-operation reset.
`timescale 1ns/1ps
module tb_des_core_arbiter;
  localparam int unsigned TO  = 8;
  localparam int unsigned TWB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_core_arbiter_if bus();
  des_core_arbiter #(.TIMEOUT(TO), .TW(TWB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        req0;
    logic        req1;
    logic [1:64] msg0;
    logic [1:64] msg1;
    int          lat;
    int          hold;
    bit          poke;
    bit          exp_owner;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          owner;
    logic [1:64] data;
    bit          err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_pass   = 0;

  bit          stub_en  = 1'b0;
  int          core_lat = 0;
  logic        stub_done = 1'b0;
  logic [1:64] stub_res  = '0;
  logic        man_done  = 1'b0;
  logic [1:64] man_res   = '0;

  assign bus.core_done   = stub_done | man_done;
  assign bus.core_result = man_done ? man_res : stub_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_k(input string name, input logic [1:768] act, input logic [1:768] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [1:768] mk_keys(input logic [1:64] s);
    logic [1:768] k;
    for (int i = 0; i < 12; i++) k[i*64+1 +: 64] = s ^ (64'(i) * 64'h9E3779B97F4A7C15);
    return k;
  endfunction

  // Stand-in for the DES core; knows the classic FIPS vector, scrambles otherwise.
  function automatic logic [1:64] core_f(input logic [1:64] m, input logic [1:768] k);
    if (m == 64'h0123456789ABCDEF) return 64'h85E813540F0AB405;
    return {m[33:64], m[1:32]} ^ k[1:64] ^ k[705:768];
  endfunction

  function automatic vec_t mkv(input logic r0, input logic r1, input logic [1:64] m0,
                               input logic [1:64] m1, input int lat, input int hold,
                               input bit poke, input bit own, input bit err);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.msg0 = m0; v.msg1 = m1; v.lat = lat; v.hold = hold;
    v.poke = poke; v.exp_owner = own; v.exp_err = err;
    return v;
  endfunction

  // Stub core: done pulse core_lat+1 cycles after the start cycle.
  initial begin : stub_core
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [1:64] res = '0;
    forever begin
      @(negedge clk);
      stub_done = 1'b0;
      if (!stub_en) pending = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          stub_done = 1'b1;
          stub_res  = res;
          pending   = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (stub_en && bus.core_start) begin
        pending = 1'b1;
        cnt     = core_lat;
        res     = core_f(bus.core_message, bus.core_round_keys);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int           waitc;
    int           exp_lat;
    exp_t         e;
    exp_t         g;
    logic [1:64]  wm;
    logic [1:768] wk;
    @(negedge clk);
    bus.rready0 = 1'b0; bus.rready1 = 1'b0;
    bus.req0 = v.req0; bus.req1 = v.req1;
    bus.msg0 = v.msg0; bus.msg1 = v.msg1;
    bus.keys0 = mk_keys(v.msg0); bus.keys1 = mk_keys(~v.msg1);
    stub_en = (v.lat >= 0); core_lat = v.lat;
    #1;
    chk($sformatf("v%0d idle_busy", idx), 64'(bus.busy), 64'd0);
    chk($sformatf("v%0d idle_rvalid", idx), 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
    waitc = 0;
    while (!(bus.ack0 || bus.ack1) && waitc < 4) begin
      @(negedge clk); #1; waitc++;
    end
    chk($sformatf("v%0d ack_delay", idx), 64'(waitc), 64'd0);
    if (!(bus.ack0 || bus.ack1)) begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      return;
    end
    chk($sformatf("v%0d ack_onehot", idx), 64'(bus.ack0 & bus.ack1), 64'd0);
    chk($sformatf("v%0d ack_owner", idx), 64'(bus.ack1), 64'(v.exp_owner));
    wm = v.exp_owner ? bus.msg1 : bus.msg0;
    wk = v.exp_owner ? bus.keys1 : bus.keys0;
    e.owner = v.exp_owner;
    e.err   = v.exp_err;
    e.data  = v.exp_err ? 64'd0 : core_f(wm, wk);
    sbq.push_back(e);

    @(negedge clk);
    if (v.exp_owner) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    #1;
    chk($sformatf("v%0d start", idx), 64'(bus.core_start), 64'd1);
    chk($sformatf("v%0d core_msg", idx), 64'(bus.core_message), 64'(wm));
    chk_k($sformatf("v%0d core_keys", idx), bus.core_round_keys, wk);

    waitc = 0;
    while (!(bus.rvalid0 || bus.rvalid1) && waitc < 40) begin
      @(negedge clk); #1; waitc++;
      chk($sformatf("v%0d start_once", idx), 64'(bus.core_start), 64'd0);
    end
    exp_lat = (v.lat < 0) ? int'(TO) + 1 : v.lat + 2;
    chk($sformatf("v%0d resp_latency", idx), 64'(waitc), 64'(exp_lat));
    g = sbq.pop_front();
    if (!(bus.rvalid0 || bus.rvalid1)) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    chk($sformatf("v%0d rvalid0", idx), 64'(bus.rvalid0), 64'(!g.owner));
    chk($sformatf("v%0d rvalid1", idx), 64'(bus.rvalid1), 64'(g.owner));
    chk($sformatf("v%0d rdata", idx), 64'(bus.rdata), 64'(g.data));
    chk($sformatf("v%0d rerr", idx), 64'(bus.rerr), 64'(g.err));

    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (g.owner) bus.rready0 = 1'b1; else bus.rready1 = 1'b1;
      if (v.poke) begin
        if (g.owner) begin bus.req0 = 1'b1; bus.msg1 = ~wm; bus.keys1 = ~wk; end
        else         begin bus.req1 = 1'b1; bus.msg0 = ~wm; bus.keys0 = ~wk; end
      end
      #1;
      chk($sformatf("v%0d hold_rdata", idx), 64'(bus.rdata), 64'(g.data));
      chk($sformatf("v%0d hold_rvalid", idx), 64'({bus.rvalid0, bus.rvalid1}),
          64'({!g.owner, g.owner}));
      chk($sformatf("v%0d hold_ack", idx), 64'({bus.ack0, bus.ack1, bus.core_start}), 64'd0);
      chk($sformatf("v%0d hold_msg", idx), 64'(bus.core_message), 64'(wm));
    end

    @(negedge clk);
    if (g.owner) begin bus.rready1 = 1'b1; bus.rready0 = 1'b0; end
    else         begin bus.rready0 = 1'b1; bus.rready1 = 1'b0; end
  endtask

  initial begin : main
    logic [1:64] m;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rready0 = 1'b0; bus.rready1 = 1'b0;
    bus.msg0 = '0; bus.msg1 = '0; bus.keys0 = '0; bus.keys1 = '0;

    vecs[0]  = mkv(1, 1, 64'hA0A0_0000_1111_2222, 64'hB1B1_3333_4444_5555, 2, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 64'h0, 64'hB1B1_3333_4444_5555, 0, 1, 0, 1, 0);
    vecs[2]  = mkv(1, 1, 64'h1000_0000_0000_0002, 64'h2000_0000_0000_0002, 1, 0, 0, 0, 0);
    vecs[3]  = mkv(1, 1, 64'h1000_0000_0000_0003, 64'h2000_0000_0000_0003, 3, 2, 0, 1, 0);
    vecs[4]  = mkv(1, 1, 64'h1000_0000_0000_0004, 64'h2000_0000_0000_0004, 5, 1, 0, 0, 0);
    vecs[5]  = mkv(1, 1, 64'h1000_0000_0000_0005, 64'h2000_0000_0000_0005, 0, 0, 0, 1, 0);
    vecs[6]  = mkv(1, 1, 64'h1000_0000_0000_0006, 64'h2000_0000_0000_0006, 2, 2, 0, 0, 0);
    vecs[7]  = mkv(1, 1, 64'h1000_0000_0000_0007, 64'h2000_0000_0000_0007, 4, 0, 0, 1, 0);
    vecs[8]  = mkv(1, 0, 64'hDEAD_BEEF_0000_0008, 64'h0, -1, 1, 0, 0, 1);
    vecs[9]  = mkv(0, 1, 64'h0, 64'hCAFE_F00D_0000_0009, 7, 0, 0, 1, 0);
    vecs[10] = mkv(1, 0, 64'h5555_AAAA_0000_000A, 64'h0, 1, 20, 1, 0, 0);
    vecs[11] = mkv(0, 1, 64'h0, 64'h7777_8888_0000_000B, 2, 0, 0, 1, 0);
    vecs[12] = mkv(1, 0, 64'h0123456789ABCDEF, 64'h0, 3, 1, 0, 0, 0);
    vecs[13] = mkv(1, 0, 64'h0F0F_1234_0000_000D, 64'h0, 6, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", 64'({bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.busy,
                          bus.core_start, bus.rerr}), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_core_msg", 64'(bus.core_message), 64'd0);
    chk_k("rst_core_keys", bus.core_round_keys, '0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Stray done pulses in START and RESP must not disturb the held result.
    m = 64'h3C3C_5A5A_0000_00C0;
    @(negedge clk);
    bus.rready0 = 1'b0; bus.rready1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b0; bus.msg0 = m; bus.keys0 = mk_keys(m); stub_en = 1'b0;
    #1 chk("c ack0", 64'(bus.ack0), 64'd1);
    @(negedge clk);
    bus.req0 = 1'b0; man_done = 1'b1; man_res = 64'h1111_1111_1111_1111;
    #1 chk("c start", 64'(bus.core_start), 64'd1);
    @(negedge clk);
    man_done = 1'b0;
    #1 chk("c no_resp_from_start_done", 64'(bus.rvalid0), 64'd0);
    @(negedge clk);
    man_done = 1'b1; man_res = core_f(m, mk_keys(m));
    @(negedge clk);
    man_done = 1'b1; man_res = 64'h2222_2222_2222_2222;
    #1;
    chk("c rvalid0", 64'(bus.rvalid0), 64'd1);
    chk("c rdata", 64'(bus.rdata), 64'(core_f(m, mk_keys(m))));
    @(negedge clk);
    man_done = 1'b0;
    #1 chk("c rdata_after_resp_done", 64'(bus.rdata), 64'(core_f(m, mk_keys(m))));
    bus.rready0 = 1'b1;

    // Reset three cycles after core_start, then a late done while idle.
    m = 64'h9999_0000_1234_00D0;
    @(negedge clk);
    bus.rready0 = 1'b0; bus.req0 = 1'b1; bus.msg0 = m; bus.keys0 = mk_keys(m);
    #1 chk("d ack0", 64'(bus.ack0), 64'd1);
    @(negedge clk);
    bus.req0 = 1'b0;
    #1 chk("d start", 64'(bus.core_start), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("d rst_outs", 64'({bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.busy,
                            bus.core_start, bus.rerr}), 64'd0);
    chk("d rst_rdata", 64'(bus.rdata), 64'd0);
    chk("d rst_core_msg", 64'(bus.core_message), 64'd0);
    chk_k("d rst_core_keys", bus.core_round_keys, '0);
    @(negedge clk);
    rst = 1'b0; man_done = 1'b1; man_res = 64'h3333_3333_3333_3333;
    @(negedge clk);
    man_done = 1'b0;
    #1;
    chk("d late_done_rvalid", 64'({bus.rvalid0, bus.rvalid1, bus.busy}), 64'd0);
    chk("d late_done_rdata", 64'(bus.rdata), 64'd0);
    run_vec(mkv(0, 1, 64'h0, 64'h4444_5555_6666_00D1, 4, 0, 0, 1, 0), 99);

    @(negedge clk);
    bus.rready0 = 1'b0; bus.rready1 = 1'b0;
    #1 chk("end idle", 64'({bus.busy, bus.rvalid0, bus.rvalid1}), 64'd0);
    chk("end sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
